// File: rtl/apb_master_if.sv
// Bundle of the user command/response handshake and the APB bus signals.
// The master modport is the view of apb_master; the slave modport is the
// view of whatever sits on the other side (user logic plus APB slave).
interface apb_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);

    // User command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // User response channel
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // APB bus
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid,
        input  cmd_wr,
        input  cmd_addr,
        input  cmd_wdata,
        output cmd_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  prdata,
        input  pready,
        input  pslverr
    );

    modport slave (
        output cmd_valid,
        output cmd_wr,
        output cmd_addr,
        output cmd_wdata,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output prdata,
        output pready,
        output pslverr
    );

endinterface

// File: rtl/apb_master.sv
// APB master: turns single user commands into APB SETUP/ACCESS transfers,
// returns a one-cycle response per command, and aborts a transfer whose
// slave keeps pready low for TIMEOUT ACCESS cycles. Back-to-back commands
// skip IDLE so psel stays high between transfers.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    apb_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Wait count seen during the last ACCESS cycle allowed before abort
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;

    logic              cmd_ready_c;
    logic              cmd_accept;
    logic              access_done;
    logic              access_abort;

    // Command readiness: free in IDLE, or when the current transfer ends now
    always_comb begin
        cmd_ready_c = 1'b0;
        case (state_q)
            IDLE:    cmd_ready_c = 1'b1;
            ACCESS:  cmd_ready_c = bus.pready;
            default: cmd_ready_c = 1'b0;
        endcase
    end

    assign cmd_accept   = bus.cmd_valid & cmd_ready_c;
    assign access_done  = (state_q == ACCESS) & bus.pready;
    assign access_abort = (state_q == ACCESS) & ~bus.pready & (wait_cnt_q == LAST_WAIT);

    // Next-state and next-output computation for the transfer FSM
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end

            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end

            ACCESS: begin
                if (access_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                end else if (access_abort) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // A new command overrides the return to IDLE and starts a SETUP phase
        if (cmd_accept) begin
            state_d    = SETUP;
            psel_d     = 1'b1;
            penable_d  = 1'b0;
            pwrite_d   = bus.cmd_wr;
            paddr_d    = bus.cmd_addr;
            pwdata_d   = bus.cmd_wdata;
            wait_cnt_d = 8'd0;
        end
    end

    // State and registered outputs, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 8, APB address width.
REQ-002 Parameter DATA_W, default 16, APB data width.
REQ-003 Parameter TIMEOUT, default 16, range 1..255, max ACCESS cycles waited for pready before abort.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  user command request.
REQ-007 cmd_ready  output  1  master accepts command this cycle.
REQ-008 cmd_wr  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  transfer address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  one-cycle pulse, transfer finished.
REQ-012 rsp_rdata  output  DATA_W  read data; 0 for writes and aborts.
REQ-013 rsp_err  output  1  pslverr at completion, or 1 on timeout; qualified by rsp_valid.
REQ-014 psel  output  1  APB select.
REQ-015 penable  output  1  APB enable.
REQ-016 pwrite  output  1  APB direction.
REQ-017 paddr  output  ADDR_W  APB address.
REQ-018 pwdata  output  DATA_W  APB write data.
REQ-019 prdata  input  DATA_W  slave read data.
REQ-020 pready  input  1  slave ready / wait-state control.
REQ-021 pslverr  input  1  slave error.

Function
REQ-022 FSM states IDLE, SETUP, ACCESS; all APB and rsp outputs registered.
REQ-023 cmd_ready = 1 in IDLE, and in ACCESS on the cycle pready=1; 0 otherwise (combinational from state and pready).
REQ-024 Accept = cmd_valid & cmd_ready; on accept latch cmd_wr/addr/wdata into pwrite/paddr/pwdata and enter SETUP next cycle.
REQ-025 SETUP: psel=1, penable=0; always moves to ACCESS after exactly one cycle.
REQ-026 ACCESS: psel=1, penable=1; paddr/pwrite/pwdata unchanged from SETUP until transfer ends.
REQ-027 ACCESS with pready=1: transfer completes; next cycle rsp_valid=1, rsp_err=pslverr, rsp_rdata=prdata if read else 0.
REQ-028 Completion with accept on same cycle: next state SETUP (psel stays 1, penable drops to 0); else IDLE with psel=penable=0.
REQ-029 Wait-state counter (8-bit) clears on SETUP entry, increments each ACCESS cycle with pready=0.
REQ-030 Timeout: ACCESS cycle number TIMEOUT with pready=0 aborts; next cycle psel=penable=0, state IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0; no command accepted on abort cycle.
REQ-031 pready=1 on the TIMEOUT-th ACCESS cycle is normal completion, not abort.
REQ-032 rsp_valid is exactly one cycle per accepted command; no backpressure on response.
REQ-033 In IDLE paddr/pwrite/pwdata hold last values; pready/prdata/pslverr ignored outside ACCESS.
REQ-034 Minimum transfer latency: accept edge to rsp_valid = 3 cycles (SETUP, ACCESS, rsp).

Reset
REQ-035 rst=0 forces IDLE immediately: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, counter = 0.
REQ-036 Reset mid-transfer drops psel/penable at once; the interrupted command produces no response.
REQ-037 After rst release, first accept possible on first rising edge with cmd_valid=1.

Verification
REQ-038 Write 0x12 <- 0xBEEF, pready=1 -> psel 2 cycles, penable 1 cycle, pwdata 0xBEEF, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-039 Read 0x34, slave waits 3 cycles, prdata=0xA5A5 -> ACCESS 4 cycles, addr stable, rsp_rdata=0xA5A5.
REQ-040 Two back-to-back writes, cmd_valid held -> psel continuous, penable 1-0-1, two rsp_valid pulses 2 cycles apart... spacing = 2 cycles.
REQ-041 TIMEOUT=4, pready held 0 -> 4 ACCESS cycles, then psel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0; pready=1 on 4th cycle -> normal completion.
REQ-042 pslverr=1 at completion of read -> rsp_err=1, rsp_rdata=prdata.
REQ-043 rst low during ACCESS -> psel/penable 0 same cycle, no rsp_valid; new command after release completes normally.
